// File: rtl/dma_pkg.sv
// Shared definitions for the DMA descriptor-chain controller: state encoding,
// status bit positions and descriptor layout.
package dma_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StFetch   = 3'd1,
        StIssue   = 3'd2,
        StWait    = 3'd3,
        StNext    = 3'd4,
        StRefetch = 3'd5,
        StError   = 3'd7
    } ctrl_state_e;

    localparam int unsigned CsrDone     = 0;
    localparam int unsigned CsrBusErr   = 1;
    localparam int unsigned CsrEngErr   = 2;
    localparam int unsigned CsrChainEnd = 3;

    localparam logic [1:0] WordNext = 2'd0;
    localparam logic [1:0] WordCtl  = 2'd1;
    localparam logic [1:0] WordSrc  = 2'd2;
    localparam logic [1:0] WordDst  = 2'd3;

    localparam int unsigned EocBit = 0;
    localparam int unsigned IrqBit = 0;

    function automatic logic [31:0] word_addr(logic [31:0] base, logic [1:0] idx);
        return base + {28'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/dma_desc_ctrl_if.sv
// Wishbone master bus plus the descriptor handshake towards the channel engine.
interface dma_desc_ctrl_if;
    logic [31:0] wbm_adr_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;
    logic        wbm_err_i;
    logic        desc_valid;
    logic        desc_ready;
    logic [31:0] desc_ctl;
    logic [31:0] desc_src;
    logic [31:0] desc_dst;
    logic        desc_done;
    logic        desc_err;

    modport master (
        output wbm_adr_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o,
        output desc_valid, desc_ctl, desc_src, desc_dst,
        input  wbm_dat_i, wbm_ack_i, wbm_err_i,
        input  desc_ready, desc_done, desc_err
    );

    modport slave (
        input  wbm_adr_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o,
        input  desc_valid, desc_ctl, desc_src, desc_dst,
        output wbm_dat_i, wbm_ack_i, wbm_err_i,
        output desc_ready, desc_done, desc_err
    );
endinterface

// File: rtl/dma_wbm_rd.sv
// Single-word Wishbone read: holds cyc/stb while req is high and flags a
// failure on err or when no ack arrives within TIMEOUT cycles.
module dma_wbm_rd #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic [31:0] addr,
    output logic [31:0] bus_adr,
    output logic        bus_cyc,
    output logic        bus_stb,
    input  logic        bus_ack,
    input  logic        bus_err,
    output logic        done,
    output logic        fail
);
    logic [7:0] cnt_q, cnt_d;
    logic       expired;

    assign bus_adr = addr;
    assign bus_cyc = req;
    assign bus_stb = req;
    assign expired = (cnt_q == 8'(TIMEOUT - 1));
    assign done    = req & bus_ack & ~bus_err;
    assign fail    = req & (bus_err | (~bus_ack & expired));

    // Counter restarts after every completed word, so the limit is per word.
    always_comb begin
        cnt_d = '0;
        if (req && !bus_ack && !bus_err && !expired) cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/dma_desc_ctrl.sv
// Descriptor-chain controller: fetches 4-word descriptors, hands them to the
// channel engine and follows the next pointers until end of chain.
module dma_desc_ctrl
    import dma_pkg::*;
#(
    parameter int unsigned FETCH_TIMEOUT = 255,
    parameter int unsigned DESC_WORDS    = 4
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_n_i,
    input  logic            enable,
    input  logic            append,
    input  logic [28:0]     ndar,
    input  logic            ndar_dirty,
    input  logic            wb_int_clear,
    output logic [31:0]     dar,
    output logic [7:0]      csr,
    output logic            busy,
    output logic            wb_int_o,
    output logic            ndar_dirty_clear,
    output logic            append_clear,
    output logic [28:0]     next_desc,
    output logic [7:0]      ctrl_state,
    dma_desc_ctrl_if.master bus
);
    localparam logic [1:0] LastIdx = 2'(DESC_WORDS - 1);

    ctrl_state_e state_q, state_d;
    logic [31:0] dar_q, dar_d, ctl_q, ctl_d, src_q, src_d, dst_q, dst_d;
    logic [28:0] next_q, next_d;
    logic [1:0]  idx_q, idx_d;
    logic [3:0]  csr_q, csr_d;
    logic        eoc_q, eoc_d, int_q, int_d, int_set;
    logic        ndc_q, ndc_d, apc_q, apc_d;
    logic        rd_req, rd_done, rd_fail;
    logic [31:0] rd_addr, rd_data, bus_adr;
    logic        bus_cyc, bus_stb;

    assign rd_data = bus.wbm_dat_i;
    assign rd_addr = (state_q == StRefetch) ? dar_q : word_addr(dar_q, idx_q);

    dma_wbm_rd #(
        .TIMEOUT (FETCH_TIMEOUT)
    ) u_rd (
        .clk     (wb_clk_i),
        .rst_n   (wb_rst_n_i),
        .req     (rd_req),
        .addr    (rd_addr),
        .bus_adr (bus_adr),
        .bus_cyc (bus_cyc),
        .bus_stb (bus_stb),
        .bus_ack (bus.wbm_ack_i),
        .bus_err (bus.wbm_err_i),
        .done    (rd_done),
        .fail    (rd_fail)
    );

    always_comb begin
        state_d = state_q;
        dar_d   = dar_q;
        idx_d   = idx_q;
        next_d  = next_q;
        eoc_d   = eoc_q;
        ctl_d   = ctl_q;
        src_d   = src_q;
        dst_d   = dst_q;
        csr_d   = csr_q;
        int_set = 1'b0;
        ndc_d   = 1'b0;
        apc_d   = 1'b0;
        rd_req  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (enable && ndar_dirty) begin
                    dar_d   = {ndar, 3'b000};
                    idx_d   = WordNext;
                    csr_d   = '0;
                    ndc_d   = 1'b1;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                rd_req = 1'b1;
                if (rd_fail) begin
                    csr_d[CsrBusErr] = 1'b1;
                    state_d          = StError;
                end else if (rd_done) begin
                    case (idx_q)
                        WordNext: begin
                            next_d = rd_data[31:3];
                            eoc_d  = rd_data[EocBit];
                        end
                        WordCtl: ctl_d = rd_data;
                        WordSrc: src_d = rd_data;
                        default: dst_d = rd_data;
                    endcase
                    if (idx_q == LastIdx) state_d = StIssue;
                    else                  idx_d   = idx_q + 2'd1;
                end
            end
            StIssue: begin
                if (bus.desc_ready) state_d = StWait;
            end
            StWait: begin
                if (bus.desc_err) begin
                    csr_d[CsrEngErr] = 1'b1;
                    state_d          = StError;
                end else if (bus.desc_done) begin
                    csr_d[CsrDone] = 1'b1;
                    int_set        = ctl_q[IrqBit];
                    state_d        = StNext;
                end
            end
            StNext: begin
                // Disable wins so a stopped chain never raises the end-of-chain irq.
                if (!enable) begin
                    state_d = StIdle;
                end else if (!eoc_q) begin
                    dar_d   = {next_q, 3'b000};
                    idx_d   = WordNext;
                    state_d = StFetch;
                end else if (append) begin
                    apc_d   = 1'b1;
                    state_d = StRefetch;
                end else begin
                    csr_d[CsrChainEnd] = 1'b1;
                    int_set            = 1'b1;
                    state_d            = StIdle;
                end
            end
            StRefetch: begin
                rd_req = 1'b1;
                if (rd_fail) begin
                    csr_d[CsrBusErr] = 1'b1;
                    state_d          = StError;
                end else if (rd_done) begin
                    next_d = rd_data[31:3];
                    eoc_d  = rd_data[EocBit];
                    if (!rd_data[EocBit]) begin
                        dar_d   = {rd_data[31:3], 3'b000};
                        idx_d   = WordNext;
                        state_d = StFetch;
                    end else begin
                        state_d = StNext;
                    end
                end
            end
            StError: begin
                if (!enable) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (state_d == StError) int_set = 1'b1;
        int_d = int_set | (int_q & ~wb_int_clear);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q <= StIdle;
            dar_q   <= '0;
            idx_q   <= '0;
            next_q  <= '0;
            eoc_q   <= 1'b0;
            ctl_q   <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            csr_q   <= '0;
            int_q   <= 1'b0;
            ndc_q   <= 1'b0;
            apc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dar_q   <= dar_d;
            idx_q   <= idx_d;
            next_q  <= next_d;
            eoc_q   <= eoc_d;
            ctl_q   <= ctl_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            csr_q   <= csr_d;
            int_q   <= int_d;
            ndc_q   <= ndc_d;
            apc_q   <= apc_d;
        end
    end

    assign dar              = dar_q;
    assign csr              = {4'b0000, csr_q};
    assign busy             = (state_q != StIdle) && (state_q != StError);
    assign wb_int_o         = int_q;
    assign ndar_dirty_clear = ndc_q;
    assign append_clear     = apc_q;
    assign next_desc        = next_q;
    assign ctrl_state       = {5'b00000, state_q};

    assign bus.wbm_adr_o  = bus_adr;
    assign bus.wbm_cyc_o  = bus_cyc;
    assign bus.wbm_stb_o  = bus_stb;
    assign bus.wbm_we_o   = 1'b0;
    assign bus.wbm_sel_o  = 4'hf;
    assign bus.desc_valid = (state_q == StIssue);
    assign bus.desc_ctl   = ctl_q;
    assign bus.desc_src   = src_q;
    assign bus.desc_dst   = dst_q;
endmodule

// File: tb/tb_dma_desc_ctrl.sv
// Directed bench for dma_desc_ctrl: memory-backed Wishbone responder, engine
// handshake driven by hand, expected values computed from the descriptor images.
module tb_dma_desc_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        append = 1'b0;
    logic [28:0] ndar = '0;
    logic        ndar_dirty = 1'b0;
    logic        wb_int_clear = 1'b0;
    logic [31:0] dar;
    logic [7:0]  csr;
    logic        busy, wb_int_o, ndar_dirty_clear, append_clear;
    logic [28:0] next_desc;
    logic [7:0]  ctrl_state;
    logic        ack_en = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] fetch_log [$];
    logic [31:0] exp_log [$];

    dma_desc_ctrl_if bus ();

    dma_desc_ctrl #(
        .FETCH_TIMEOUT (8)
    ) dut (
        .wb_clk_i         (clk),
        .wb_rst_n_i       (rst_n),
        .enable           (enable),
        .append           (append),
        .ndar             (ndar),
        .ndar_dirty       (ndar_dirty),
        .wb_int_clear     (wb_int_clear),
        .dar              (dar),
        .csr              (csr),
        .busy             (busy),
        .wb_int_o         (wb_int_o),
        .ndar_dirty_clear (ndar_dirty_clear),
        .append_clear     (append_clear),
        .next_desc        (next_desc),
        .ctrl_state       (ctrl_state),
        .bus              (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rd_mem(logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'h0;
    endfunction

    assign bus.wbm_dat_i = rd_mem(bus.wbm_adr_o);
    assign bus.wbm_ack_i = ack_en & bus.wbm_cyc_o & bus.wbm_stb_o;
    assign bus.wbm_err_i = 1'b0;

    always @(posedge clk) begin
        if (bus.wbm_cyc_o && bus.wbm_stb_o && bus.wbm_ack_i) fetch_log.push_back(bus.wbm_adr_o);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic wait_st(input string tag, input logic [7:0] st, input int budget);
        int n = 0;
        while (ctrl_state !== st && n < budget) begin
            tick();
            n++;
        end
        chk(tag, {24'd0, ctrl_state}, {24'd0, st});
    endtask

    task automatic start(input logic [31:0] addr);
        ndar       = addr[31:3];
        ndar_dirty = 1'b1;
        tick();
        chk("start_state", {24'd0, ctrl_state}, 32'd1);
        chk("start_ndc", {31'd0, ndar_dirty_clear}, 32'd1);
        ndar_dirty = 1'b0;
    endtask

    // From ISSUE: accept the descriptor, then report completion.
    task automatic engine();
        bus.desc_ready = 1'b1;
        tick();
        bus.desc_ready = 1'b0;
        bus.desc_done  = 1'b1;
        tick();
        bus.desc_done  = 1'b0;
    endtask

    task automatic chk_log(input string tag);
        chk({tag, "_len"}, fetch_log.size(), exp_log.size());
        for (int i = 0; i < exp_log.size() && i < fetch_log.size(); i++)
            chk(tag, fetch_log[i], exp_log[i]);
    endtask

    initial begin
        logic stable;
        int   n;
        bus.desc_ready = 1'b0;
        bus.desc_done  = 1'b0;
        bus.desc_err   = 1'b0;
        mem[32'h1000] = 32'h0000_2000;
        mem[32'h1004] = 32'h0000_0010;
        mem[32'h1008] = 32'hAAAA_0000;
        mem[32'h100C] = 32'hBBBB_0000;
        mem[32'h2000] = 32'h0000_0001;
        mem[32'h2004] = 32'h0000_0020;
        mem[32'h2008] = 32'hCCCC_0000;
        mem[32'h200C] = 32'hDDDD_0000;
        mem[32'h4000] = 32'h0000_0001;
        mem[32'h4004] = 32'h0000_0000;
        mem[32'h3000] = 32'h0000_0001;
        mem[32'h3004] = 32'h0000_0001;
        mem[32'h5000] = 32'h0000_6000;
        mem[32'h5004] = 32'h0000_0000;

        tick();
        tick();
        chk("rst_state", {24'd0, ctrl_state}, 32'd0);
        chk("rst_dar", dar, 32'd0);
        chk("rst_csr", {24'd0, csr}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_int", {31'd0, wb_int_o}, 32'd0);
        chk("rst_cyc", {31'd0, bus.wbm_cyc_o}, 32'd0);
        chk("rst_valid", {31'd0, bus.desc_valid}, 32'd0);
        rst_n  = 1'b1;
        enable = 1'b1;
        tick();

        // Two-descriptor chain 0x1000 -> 0x2000 (eoc).
        fetch_log.delete();
        start(32'h1000);
        chk("c1_dar", dar, 32'h1000);
        chk("c1_busy", {31'd0, busy}, 32'd1);
        wait_st("c1_issue", 8'd2, 20);
        chk("c1_ctl", bus.desc_ctl, 32'h0000_0010);
        chk("c1_src", bus.desc_src, 32'hAAAA_0000);
        chk("c1_dst", bus.desc_dst, 32'hBBBB_0000);
        chk("c1_next", {3'd0, next_desc}, 32'h400);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!(bus.desc_valid === 1'b1 && bus.desc_src === 32'hAAAA_0000 &&
                  bus.desc_ctl === 32'h10 && ctrl_state === 8'd2)) stable = 1'b0;
        end
        chk("stall_stable", {31'd0, stable}, 32'd1);
        chk("stall_nofetch", fetch_log.size(), 32'd4);
        engine();
        chk("c1_next_st", {24'd0, ctrl_state}, 32'd4);
        chk("c1_csr_done", {24'd0, csr}, 32'h1);
        wait_st("c2_issue", 8'd2, 20);
        chk("c2_dar", dar, 32'h2000);
        chk("c2_src", bus.desc_src, 32'hCCCC_0000);
        engine();
        wait_st("c2_idle", 8'd0, 5);
        chk("c2_csr", {24'd0, csr}, 32'h9);
        chk("c2_int", {31'd0, wb_int_o}, 32'd1);
        chk("c2_busy", {31'd0, busy}, 32'd0);
        exp_log = {32'h1000, 32'h1004, 32'h1008, 32'h100C,
                   32'h2000, 32'h2004, 32'h2008, 32'h200C};
        chk_log("c_log");
        wb_int_clear = 1'b1;
        tick();
        wb_int_clear = 1'b0;
        chk("int_clear", {31'd0, wb_int_o}, 32'd0);

        // Append at end of chain: word0 rewritten to point at 0x3000.
        fetch_log.delete();
        append = 1'b1;
        start(32'h4000);
        wait_st("a_issue", 8'd2, 20);
        mem[32'h4000] = 32'h0000_3000;
        engine();
        wait_st("a_refetch", 8'd5, 5);
        chk("a_apc", {31'd0, append_clear}, 32'd1);
        append = 1'b0;
        tick();
        chk("a_fetch", {24'd0, ctrl_state}, 32'd1);
        chk("a_dar", dar, 32'h3000);
        wait_st("a_issue2", 8'd2, 20);
        chk("a_ctl", bus.desc_ctl, 32'h1);
        chk("a_int_pre", {31'd0, wb_int_o}, 32'd0);
        bus.desc_ready = 1'b1;
        tick();
        bus.desc_ready = 1'b0;
        bus.desc_done  = 1'b1;
        wb_int_clear   = 1'b1;
        tick();
        bus.desc_done  = 1'b0;
        wb_int_clear   = 1'b0;
        chk("a_int_prio", {31'd0, wb_int_o}, 32'd1);
        wait_st("a_idle", 8'd0, 5);
        chk("a_csr", {24'd0, csr}, 32'h9);
        exp_log = {32'h4000, 32'h4004, 32'h4008, 32'h400C, 32'h4000,
                   32'h3000, 32'h3004, 32'h3008, 32'h300C};
        chk_log("a_log");
        wb_int_clear = 1'b1;
        tick();
        wb_int_clear = 1'b0;

        // Disable while the engine runs: descriptor completes, no next fetch.
        fetch_log.delete();
        start(32'h5000);
        wait_st("d_issue", 8'd2, 20);
        bus.desc_ready = 1'b1;
        tick();
        bus.desc_ready = 1'b0;
        chk("d_wait", {24'd0, ctrl_state}, 32'd3);
        enable = 1'b0;
        tick();
        chk("d_still_wait", {24'd0, ctrl_state}, 32'd3);
        bus.desc_done = 1'b1;
        tick();
        bus.desc_done = 1'b0;
        wait_st("d_idle", 8'd0, 5);
        chk("d_int", {31'd0, wb_int_o}, 32'd0);
        chk("d_csr", {24'd0, csr}, 32'h1);
        chk("d_dar", dar, 32'h5000);
        repeat (3) tick();
        chk("d_nofetch", fetch_log.size(), 32'd4);

        // Fetch timeout: no ack for 8 cycles.
        enable = 1'b1;
        ack_en = 1'b0;
        start(32'h7000);
        n = 0;
        while (ctrl_state === 8'd1 && n < 50) begin
            n++;
            tick();
        end
        chk("t_cycles", n, 32'd8);
        chk("t_state", {24'd0, ctrl_state}, 32'd7);
        chk("t_csr", {24'd0, csr}, 32'h2);
        chk("t_int", {31'd0, wb_int_o}, 32'd1);
        chk("t_busy", {31'd0, busy}, 32'd0);
        repeat (3) tick();
        chk("t_hold", {24'd0, ctrl_state}, 32'd7);
        ack_en = 1'b1;
        enable = 1'b0;
        tick();
        chk("t_idle", {24'd0, ctrl_state}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dma_desc_ctrl.md
Name: dma_desc_ctrl

Overview:
Descriptor-chain controller for the DMA. It sits directly upstream of the Wishbone slave register block: it consumes that block's enable, append, ndar, ndar_dirty and wb_int_clear, and produces the dar, csr, busy, wb_int_o, ndar_dirty_clear, append_clear, next_desc and ctrl_state values that block reads back. It fetches 4-word descriptors over a Wishbone master port and hands each one to the channel engine through a valid/ready handshake.

Parameters:
FETCH_TIMEOUT, 255, max cycles waiting for wbm_ack_i per word before a bus error (1..255).
DESC_WORDS, 4, words per descriptor (fixed; never overridden).

Ports:
wb_clk_i  in  1  clock
wb_rst_n_i  in  1  asynchronous active-low reset
enable  in  1  controller enable (CCR bit1)
append  in  1  software appended descriptors
ndar  in  29  [31:3] next descriptor address from software
ndar_dirty  in  1  ndar written, not yet consumed
wb_int_clear  in  1  one-cycle interrupt clear
dar  out  32  current descriptor address
csr  out  8  status
busy  out  1  chain in progress
wb_int_o  out  1  interrupt
ndar_dirty_clear  out  1  one-cycle pulse
append_clear  out  1  one-cycle pulse
next_desc  out  29  [31:3] next pointer of current descriptor
ctrl_state  out  8  encoded FSM state
wbm_adr_o  out  32  master address
wbm_cyc_o, wbm_stb_o  out  1  master cycle/strobe
wbm_we_o  out  1  tied 0
wbm_sel_o  out  4  tied 4'hf
wbm_dat_i  in  32  read data
wbm_ack_i, wbm_err_i  in  1  ack / error
desc_valid  out  1  descriptor offered to engine
desc_ready  in  1  engine accepts
desc_ctl  out  32  word1: [0] irq-on-done, [23:0] used by engine as byte count
desc_src, desc_dst  out  32  words 2 and 3
desc_done, desc_err  in  1  engine completion / error pulse

Behaviour:
- Reset: all outputs 0; FSM IDLE.
- Descriptor at A: word0 = {next[31:3], 2'b0, eoc}, words 1–3 at A+4, A+8, A+12.
- Next pointer and end-of-chain: next_desc is loaded from word0[31:3] and eoc from word0[0].
- IDLE: when enable && ndar_dirty, load dar <= {ndar, 3'b0}, pulse ndar_dirty_clear, go to FETCH. busy=1 in every state except IDLE and ERROR.
- FETCH: issue single reads with cyc and stb held high for each word until ack or err, one word at a time, adr = dar + 4*idx.
  - The timeout counter resets per word.
  - err or timeout → ERROR with csr[1]=1.
  - After the word-3 ack, go to ISSUE.
- ISSUE: hold desc_valid=1 with stable fields until desc_ready is sampled high, then go to WAIT.
- WAIT: on desc_err go to ERROR with csr[2]=1. On desc_done, set csr[0] (and set wb_int_o if desc_ctl[0]), then go to NEXT.
- NEXT:
  - If !eoc and enable: dar <= {next_desc, 3'b0}, go to FETCH.
  - If eoc and append: pulse append_clear, then refetch word0 only at the same dar (state REFETCH, same timeout rules).
    - If the new word0 has eoc=0, advance to its next pointer and go to FETCH.
    - Otherwise return to NEXT with append now 0.
  - If eoc and !append: csr[3]=1, wb_int_o=1, go to IDLE.
  - If !enable: go to IDLE without interrupt.
- Disable mid-chain: the current descriptor completes (no engine abort), then NEXT goes to IDLE.
- ERROR: busy=0 and wb_int_o=1. Exit to IDLE only when enable is low.
- csr: bits[3:0] are sticky until the next IDLE→FETCH start, where they clear. Bits[7:4] are 0.
- wb_int_o: set has priority over wb_int_clear in the same cycle.
- ctrl_state: IDLE=0, FETCH=1, ISSUE=2, WAIT=3, NEXT=4, REFETCH=5, ERROR=7.
- ndar_dirty arriving while busy is ignored until IDLE.

Decomposition:
- Package dma_pkg holds the state encoding, csr bit indices, descriptor word offsets and the EOC/IRQ bit positions.
- Sub-module dma_wbm_rd is a single-word Wishbone read with a timeout counter. It is used by both FETCH and REFETCH.

Test Plan:
- ndar=0x1000, two descriptors (0x1000→0x2000 eoc) with acks → fetch addresses 0x1000..0x100C, 0x2000..0x200C; csr=0x9; wb_int_o=1; busy=0.
- desc_ready held low for 10 cycles → desc_valid stays high and fields stay stable; no further fetch.
- wbm_ack_i withheld, FETCH_TIMEOUT=8 → ERROR after 8 cycles; csr[1]=1; wb_int_o=1; IDLE only after enable=0.
- eoc reached with append=1, refetched word0=0x3000 → append_clear pulse, fetch from 0x3000.
- enable dropped during WAIT, then desc_done → IDLE; no fetch at the next pointer; wb_int_o follows the irq bit only.
- wb_int_clear coincident with desc_done (irq=1) → wb_int_o remains 1.
